// File: rtl/decode.sv
// RV32I decode stage: register file, immediate and control decode,
// load-use stall detection and the registered id_ex bundle.
module decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_id__pc,
  input  logic [31:0] if_id__ins,
  input  logic        if_id__ins_misalign,
  input  logic        pipe_flush,
  input  logic        mb_id__jump_taken,
  input  logic        wb_id__rd_we,
  input  logic [4:0]  wb_id__rd,
  input  logic [31:0] wb_id__rd_data,
  output logic        data_hazard,
  output logic        id_ex__valid,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__rs1_data,
  output logic [31:0] id_ex__rs2_data,
  output logic [31:0] id_ex__imm,
  output logic [4:0]  id_ex__rd,
  output logic [3:0]  id_ex__alu_op,
  output logic [6:0]  id_ex__ctl,
  output logic [1:0]  id_ex__trap
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [4:0]  rd_f;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;

  assign ins    = if_id__ins;
  assign opcode = ins[6:0];
  assign rd_f   = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_branch, is_load, is_store;
  logic is_opimm, is_op;
  logic is_i, is_u, legal, writes, exec;
  logic use_rs1, use_rs2, kill;

  assign is_lui    = opcode == OP_LUI;
  assign is_auipc  = opcode == OP_AUIPC;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign is_branch = opcode == OP_BRANCH;
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_opimm  = opcode == OP_OPIMM;
  assign is_op     = opcode == OP_OP;

  assign is_i   = is_jalr | is_load | is_opimm;
  assign is_u   = is_lui | is_auipc;
  assign legal  = is_u | is_jal | is_i | is_branch
                | is_store | is_op;
  assign writes = is_u | is_jal | is_i | is_op;
  assign exec   = legal & ~if_id__ins_misalign;

  assign use_rs1 = ~(is_u | is_jal);
  assign use_rs2 = is_op | is_store | is_branch;
  assign kill    = pipe_flush | mb_id__jump_taken;

  // Stall fetch when the load now in EX feeds a source of this instruction
  assign data_hazard = id_ex__valid & id_ex__ctl[5]
                     & (id_ex__rd != 5'd0)
                     & ((id_ex__rd == rs1 & use_rs1)
                      | (id_ex__rd == rs2 & use_rs2))
                     & ~kill;

  logic [31:0] rf [32];

  // Register file write port; x0 is never written
  always_ff @(posedge clk) begin
    if (wb_id__rd_we && wb_id__rd != 5'd0)
      rf[wb_id__rd] <= wb_id__rd_data;
  end

  logic [31:0] d_rs1_data;
  logic [31:0] d_rs2_data;

  // Async reads with write-through bypass from writeback
  always_comb begin
    d_rs1_data = '0;
    d_rs2_data = '0;
    if (rs1 != 5'd0)
      d_rs1_data = (wb_id__rd_we && wb_id__rd == rs1)
                 ? wb_id__rd_data : rf[rs1];
    if (rs2 != 5'd0)
      d_rs2_data = (wb_id__rd_we && wb_id__rd == rs2)
                 ? wb_id__rd_data : rf[rs2];
  end

  logic [31:0] d_imm;

  // Immediate format selected by instruction type
  always_comb begin
    d_imm = '0;
    unique case (1'b1)
      is_i:      d_imm = {{20{ins[31]}}, ins[31:20]};
      is_store:  d_imm = {{20{ins[31]}}, ins[31:25],
                         ins[11:7]};
      is_branch: d_imm = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
      is_u:      d_imm = {ins[31:12], 12'b0};
      is_jal:    d_imm = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
      default:   d_imm = '0;
    endcase
  end

  logic [6:0] d_ctl;
  logic [4:0] d_rd;
  logic [3:0] d_alu;
  logic [1:0] d_trap;
  logic       d_sub;

  // Control fields; illegal or misaligned instructions do nothing
  always_comb begin
    d_sub  = ins[30] & (is_op | (is_opimm & f3 == 3'b101));
    d_alu  = {d_sub, f3};
    d_trap = {~legal, if_id__ins_misalign};
    d_ctl  = '0;
    d_rd   = '0;
    if (exec) begin
      d_ctl = {writes & (rd_f != 5'd0), is_load, is_store,
               is_branch, is_jal, is_jalr, is_u};
      d_rd  = d_ctl[6] ? rd_f : 5'd0;
    end
  end

  // ID/EX register: reset, bubble on kill/hazard, else decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex__valid    <= 1'b0;
      id_ex__pc       <= RESET_PC;
      id_ex__rs1_data <= '0;
      id_ex__rs2_data <= '0;
      id_ex__imm      <= '0;
      id_ex__rd       <= '0;
      id_ex__alu_op   <= '0;
      id_ex__ctl      <= '0;
      id_ex__trap     <= '0;
    end else if (kill || data_hazard) begin
      id_ex__valid    <= 1'b0;
      id_ex__ctl      <= '0;
      id_ex__rd       <= '0;
      id_ex__trap     <= '0;
    end else begin
      id_ex__valid    <= 1'b1;
      id_ex__pc       <= if_id__pc;
      id_ex__rs1_data <= d_rs1_data;
      id_ex__rs2_data <= d_rs2_data;
      id_ex__imm      <= d_imm;
      id_ex__rd       <= d_rd;
      id_ex__alu_op   <= d_alu;
      id_ex__ctl      <= d_ctl;
      id_ex__trap     <= d_trap;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboarded random + directed bench for the decode stage.
// Expected id_ex and data_hazard come from a reference model.
module tb_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic        if_mis;
  logic        flush;
  logic        jt;
  logic        we;
  logic [4:0]  wrd;
  logic [31:0] wdat;
  logic        data_hazard;
  logic        v;
  logic [31:0] o_pc, o_r1, o_r2, o_imm;
  logic [4:0]  o_rd;
  logic [3:0]  o_alu;
  logic [6:0]  o_ctl;
  logic [1:0]  o_trap;

  decode #(.RESET_PC(32'h40)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_id__pc(if_pc),
    .if_id__ins(if_ins),
    .if_id__ins_misalign(if_mis),
    .pipe_flush(flush),
    .mb_id__jump_taken(jt),
    .wb_id__rd_we(we),
    .wb_id__rd(wrd),
    .wb_id__rd_data(wdat),
    .data_hazard(data_hazard),
    .id_ex__valid(v),
    .id_ex__pc(o_pc),
    .id_ex__rs1_data(o_r1),
    .id_ex__rs2_data(o_r2),
    .id_ex__imm(o_imm),
    .id_ex__rd(o_rd),
    .id_ex__alu_op(o_alu),
    .id_ex__ctl(o_ctl),
    .id_ex__trap(o_trap)
  );

  localparam bit [6:0] LUI = 7'h37, AUIPC = 7'h17;
  localparam bit [6:0] JAL = 7'h6F, JALR = 7'h67;
  localparam bit [6:0] BR = 7'h63, LD = 7'h03;
  localparam bit [6:0] ST = 7'h23, OPI = 7'h13;
  localparam bit [6:0] OPR = 7'h33;
  localparam int K_BUB = 0, K_FULL = 1, K_RST = 2;

  typedef struct {
    int        kind;
    bit [31:0] pc, r1, r2, imm;
    bit        chk_imm;
    bit [4:0]  rd;
    bit [3:0]  alu;
    bit [6:0]  ctl;
    bit [1:0]  trap;
  } exp_t;

  typedef struct {
    bit chk;
    bit hz;
  } hz_t;

  exp_t      eq[$];
  hz_t       hq[$];
  bit [31:0] m_rf [32];
  bit        p_known, p_valid, p_mr;
  bit [4:0]  p_rd;
  int        checks = 0;
  int        fails = 0;
  bit [31:0] cur_pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit [31:0] pc, ins,
                                 input bit mis,
                                 input bit [31:0] r1, r2);
    exp_t     e;
    bit [6:0] op;
    bit [2:0] f3;
    bit       wr, legal;
    bit [31:0] s11, s12, s20;
    op = ins[6:0];
    f3 = ins[14:12];
    s11 = ins[31] ? 32'hFFFF_F800 : 32'h0;
    s12 = ins[31] ? 32'hFFFF_F000 : 32'h0;
    s20 = ins[31] ? 32'hFFF0_0000 : 32'h0;
    e.kind = K_FULL;
    e.pc = pc;
    e.r1 = r1;
    e.r2 = r2;
    e.chk_imm = 1'b1;
    e.imm = 32'h0;
    legal = 1'b1;
    wr = 1'b0;
    case (op)
      LUI, AUIPC: begin
        e.imm = ins & 32'hFFFF_F000;
        wr = 1'b1;
      end
      JAL: begin
        e.imm = s20 + (32'(ins[19:12]) << 12)
              + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
        wr = 1'b1;
      end
      JALR, LD, OPI: begin
        e.imm = s11 + 32'(ins[30:20]);
        wr = 1'b1;
      end
      ST: e.imm = s11 + (32'(ins[30:25]) << 5) + 32'(ins[11:7]);
      BR: e.imm = s12 + (32'(ins[7]) << 11)
                + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
      OPR: begin
        wr = 1'b1;
        e.chk_imm = 1'b0;
      end
      default: begin
        legal = 1'b0;
        e.chk_imm = 1'b0;
      end
    endcase
    e.trap = {!legal, mis};
    e.alu = {ins[30] && (op == OPR || (op == OPI && f3 == 3'd5)), f3};
    if (!legal || mis) begin
      e.ctl = 7'h0;
      e.rd = 5'h0;
    end else begin
      e.rd = wr ? ins[11:7] : 5'd0;
      e.ctl = {wr && ins[11:7] != 5'd0, op == LD, op == ST,
               op == BR, op == JAL, op == JALR,
               op == LUI || op == AUIPC};
    end
    return e;
  endfunction

  task automatic issue(input bit rst, input bit [31:0] pc, ins,
                       input bit mis, fl, j, w,
                       input bit [4:0] wr_rd, input bit [31:0] wd,
                       output bit hz_out);
    exp_t      e;
    hz_t       h;
    bit [6:0]  op;
    bit [4:0]  a, b;
    bit        u1, u2, hz;
    bit [31:0] r1, r2;
    @(posedge clk);
    #2;
    rst_n = rst;
    if_pc = pc;
    if_ins = ins;
    if_mis = mis;
    flush = fl;
    jt = j;
    we = w;
    wrd = wr_rd;
    wdat = wd;
    op = ins[6:0];
    a = ins[19:15];
    b = ins[24:20];
    u1 = !(op == LUI || op == AUIPC || op == JAL);
    u2 = (op == OPR || op == ST || op == BR);
    hz = p_valid && p_mr && p_rd != 0
       && ((p_rd == a && u1) || (p_rd == b && u2)) && !fl && !j;
    h.chk = p_known;
    h.hz = hz;
    hq.push_back(h);
    r1 = (a == 0) ? 32'h0 : (w && wr_rd == a) ? wd : m_rf[a];
    r2 = (b == 0) ? 32'h0 : (w && wr_rd == b) ? wd : m_rf[b];
    if (!rst) begin
      e = '{default: 0};
      e.kind = K_RST;
    end else if (fl || j || hz) begin
      e = '{default: 0};
      e.kind = K_BUB;
    end else begin
      e = model(pc, ins, mis, r1, r2);
    end
    eq.push_back(e);
    p_known = 1'b1;
    p_valid = (e.kind == K_FULL);
    p_mr = e.ctl[5];
    p_rd = e.rd;
    if (w && wr_rd != 0) m_rf[wr_rd] = wd;
    hz_out = hz && rst;
  endtask

  task automatic send(input bit [31:0] ins, input bit fl,
                      input bit w, input bit [4:0] wr_rd,
                      input bit [31:0] wd);
    bit hz;
    int n;
    n = 0;
    do begin
      issue(1'b1, cur_pc, ins, 1'b0, fl, 1'b0, w, wr_rd, wd, hz);
      n++;
    end while (hz && n < 4);
    cur_pc += 4;
  endtask

  function automatic bit [31:0] rand_ins();
    bit [6:0]  ops [12];
    bit [31:0] i;
    ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR,
            7'h0F, 7'h73, 7'h7F};
    i = $urandom;
    i[6:0] = ops[$urandom % 12];
    i[11:7] = 5'($urandom % 8);
    i[19:15] = 5'($urandom % 8);
    i[24:20] = 5'($urandom % 8);
    return i;
  endfunction

  // Hazard monitor: combinational output sampled mid-cycle
  always @(negedge clk) begin
    hz_t h;
    if (hq.size() > 0) begin
      h = hq.pop_front();
      if (h.chk) chk("data_hazard", 32'(data_hazard), 32'(h.hz));
    end
  end

  // id_ex monitor: compares the registered bundle after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("valid", 32'(v), 32'(e.kind == K_FULL));
      chk("ctl", 32'(o_ctl), 32'(e.ctl));
      chk("rd", 32'(o_rd), 32'(e.rd));
      chk("trap", 32'(o_trap), 32'(e.trap));
      if (e.kind == K_RST) begin
        chk("rst_pc", o_pc, 32'h40);
        chk("rst_rs1", o_r1, 32'h0);
        chk("rst_rs2", o_r2, 32'h0);
        chk("rst_imm", o_imm, 32'h0);
        chk("rst_alu", 32'(o_alu), 32'h0);
      end
      if (e.kind == K_FULL) begin
        chk("pc", o_pc, e.pc);
        chk("rs1_data", o_r1, e.r1);
        chk("rs2_data", o_r2, e.r2);
        chk("alu_op", 32'(o_alu), 32'(e.alu));
        if (e.chk_imm) chk("imm", o_imm, e.imm);
      end
    end
  end

  initial begin
    bit        hz, hold, rst, fl, j, w, mis;
    bit [31:0] pc, ins;
    bit [4:0]  r;
    rst_n = 1'b0;
    if_pc = 32'h0;
    if_ins = 32'h13;
    if_mis = 1'b0;
    flush = 1'b0;
    jt = 1'b0;
    we = 1'b0;
    wrd = 5'd0;
    wdat = 32'h0;
    p_known = 1'b0;
    p_valid = 1'b0;
    p_mr = 1'b0;
    p_rd = 5'd0;

    issue(1'b0, 32'h0, 32'h13, 0, 0, 0, 0, 5'd0, 32'h0, hz);
    issue(1'b0, 32'h0, 32'h13, 0, 0, 0, 0, 5'd0, 32'h0, hz);

    cur_pc = 32'h100;
    for (int k = 1; k < 32; k++)
      send(32'h13, 1'b0, 1'b1, 5'(k), $urandom);

    cur_pc = 32'h40;
    send(32'hFFF0_0293, 1'b0, 1'b0, 5'd0, 32'h0);
    send(32'h0000_A303, 1'b0, 1'b0, 5'd0, 32'h0);
    send(32'h0023_03B3, 1'b0, 1'b0, 5'd0, 32'h0);
    send(32'h0000_A003, 1'b0, 1'b0, 5'd0, 32'h0);
    send(32'h0020_03B3, 1'b0, 1'b0, 5'd0, 32'h0);
    send(32'h0031_8233, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    send(32'h0020_8463, 1'b1, 1'b0, 5'd0, 32'h0);
    send(32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);

    send(32'h0000_A303, 1'b0, 1'b0, 5'd0, 32'h0);
    issue(1'b0, cur_pc, 32'h0023_03B3, 0, 0, 0, 0, 5'd0, 32'h0, hz);
    send(32'h0023_03B3, 1'b0, 1'b0, 5'd0, 32'h0);

    hold = 1'b0;
    pc = 32'h200;
    ins = 32'h13;
    mis = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        ins = rand_ins();
        pc = pc + 4;
        mis = ($urandom % 16) == 0;
      end
      rst = ($urandom % 64) != 0;
      fl = ($urandom % 8) == 0;
      j = ($urandom % 10) == 0;
      w = $urandom % 2;
      r = 5'($urandom % 8);
      issue(rst, pc, ins, mis, fl, j, w, r, $urandom, hz);
      hold = hz;
    end

    send(32'h13, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
